// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states
// and a helper for the alignment check.
package dm_lsu_pkg;

  localparam int unsigned LSU_DW = 32;

  typedef logic [1:0] lsu_size_t;

  localparam lsu_size_t SZ_BYTE = 2'd0;
  localparam lsu_size_t SZ_HALF = 2'd1;
  localparam lsu_size_t SZ_WORD = 2'd2;
  localparam lsu_size_t SZ_ILL  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RMW   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Illegal size or a byte offset that is not a multiple of the access size.
  function automatic logic align_err(input lsu_size_t size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = |addr_lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Bus bundle for dm_lsu: CPU request/response handshake plus the data-memory port.
// master = CPU datapath, slave = load/store unit, mem = the memory itself.
interface dm_lsu_if #(
  parameter int unsigned ADDR_W = 10
);
  import dm_lsu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  lsu_size_t            req_size;
  logic                 req_unsigned;
  logic [LSU_DW-1:0]    req_addr;
  logic [LSU_DW-1:0]    req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [LSU_DW-1:0]    resp_rdata;
  logic                 resp_err;
  logic [ADDR_W-1:0]    dm_addr;
  logic [LSU_DW-1:0]    dm_din;
  logic                 dm_we;
  logic [LSU_DW-1:0]    dm_dout;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_din, dm_we,
    input  dm_dout
  );

  modport mem (
    input  dm_addr, dm_din, dm_we,
    output dm_dout
  );

endinterface

// File: rtl/dm_lsu_lane.sv
// Combinational lane logic: little-endian byte/half select with sign/zero extension
// for loads, and merge of store data into the addressed lane for read-modify-write.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_ofs;

  always_comb begin
    byte_ofs = {addr_lo, 3'b000};
    byte_sel = rdata[byte_ofs +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase

    merge_data = rdata;
    case (size)
      SZ_BYTE: merge_data[byte_ofs +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) merge_data[31:16] = wdata;
        else            merge_data[15:0]  = wdata;
      end
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator for the word-addressed data memory; sub-word stores use
// read-modify-write. Define DM_LSU_RANGE_CHECK_EN to flag out-of-range addresses.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = LSU_DW
) (
  input logic     clk,
  input logic     rst_n,
  dm_lsu_if.slave bus
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  lsu_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  always_comb begin
    req_err = align_err(bus.req_size, bus.req_addr[1:0]);
`ifdef DM_LSU_RANGE_CHECK_EN
    req_err = req_err | (|bus.req_addr[31:ADDR_W+2]);
`endif
  end

  // buf_q holds raw store data until RMW replaces it with the merged word.
  dm_lsu_lane u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .rdata       (bus.dm_dout),
    .wdata       (buf_q[15:0]),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr[ADDR_W+1:0];
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          buf_d   = bus.req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                  state_d = ST_RESP;
          else if (!bus.req_we)         state_d = ST_LOAD;
          else if (bus.req_size == SZ_WORD) state_d = ST_WRITE;
          else                          state_d = ST_RMW;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW: begin
        buf_d   = merge_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.dm_addr    = addr_q[ADDR_W+1:2];
  assign bus.dm_din     = buf_q;
  assign bus.dm_we      = (state_q == ST_WRITE);

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed vector table, reset/backpressure sequences
// and random traffic against a byte-array reference model.
module tb_dm_lsu;

  localparam int unsigned AW = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dm_lsu_if #(.ADDR_W(AW)) bus ();

  dm_lsu #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign bus.dm_dout = mem[bus.dm_addr];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory viewed as a flat byte array, little-endian within each word.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int wes);
    int unsigned nb, base, w, sh;
    logic [31:0] v;
    er = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef DM_LSU_RANGE_CHECK_EN
    er = er || ((addr >> (AW + 2)) != 0);
`endif
    rd  = 32'h0;
    wes = 0;
    lat = 1;
    if (er) return;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = addr % (32'd1 << (AW + 2));
    if (!we) begin
      v = 32'h0;
      for (int unsigned i = 0; i < nb; i++) begin
        w  = (base + i) / 4;
        sh = 8 * ((base + i) % 4);
        v  = v | (((ref_mem[w] >> sh) & 32'hFF) << (8 * i));
      end
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rd  = v;
      lat = 2;
    end else begin
      for (int unsigned i = 0; i < nb; i++) begin
        w  = (base + i) / 4;
        sh = 8 * ((base + i) % 4);
        ref_mem[w] = (ref_mem[w] & ~(32'hFF << sh)) | (((wdata >> (8 * i)) & 32'hFF) << sh);
      end
      lat = (nb == 4) ? 2 : 3;
      wes = 1;
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                      output logic [31:0] rd_first, output logic [31:0] rd, output logic er,
                      output int lat, output int wes);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.resp_ready   = (stall == 0);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    wes = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
      if (bus.dm_we) wes++;
    end while (!bus.resp_valid && lat < 10);
    rd_first = bus.resp_rdata;
    er       = bus.resp_err;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      if (bus.dm_we) wes++;
    end
    rd = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd_first, rd, m_rd, addr, wdata;
    logic        er, m_er, we, uns;
    logic [1:0]  size;
    int          lat, wes, m_lat, m_wes, n, stall;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b0;
    rst_n            = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_dm_we", 32'(bus.dm_we), 32'd0);
    check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    check("rst_dm_din", bus.dm_din, 32'h0);
    rst_n = 1'b1;

    // we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_wes
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0, 2, 1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11223344, 1'b0, 2, 0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h11,  32'hFFFFFFAB, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFFAB, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h000000AB, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1122AB44, 1'b0, 2, 0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12,  32'hDEAD8001, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF8001, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8001AB44, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1, 0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h06,  32'h55555555, 32'h0,        1'b1, 1, 0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        32'h0,        1'b1, 1, 0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h04,  32'h12345678, 32'h0,        1'b1, 1, 0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h17,  32'hFFFFFF7F, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h17,  32'h0,        32'h0000007F, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h16,  32'h0,        32'h00007F00, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h14,  32'h0,        32'h00000000, 1'b0, 2, 0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'hFFC, 32'h0,        32'h0000000D, 1'b0, 2, 0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0,   32'h0BADBEEF, 32'h0,        1'b0, 2, 1});
`ifdef DM_LSU_RANGE_CHECK_EN
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 1, 0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1004, 32'h77777777, 32'h0,       1'b1, 1, 0});
`else
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,       32'h0BADBEEF, 1'b0, 2, 0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1004, 32'h77777777, 32'h0,       1'b0, 2, 1});
`endif

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
           rd_first, rd, er, lat, wes);
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
            m_rd, m_er, m_lat, m_wes);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_we_pulses", i), 32'(wes), 32'(vecs[i].exp_wes));
      check($sformatf("vec%0d_mem_word", i), mem[vecs[i].addr[11:2]],
            ref_mem[vecs[i].addr[11:2]]);
    end

    // Reset during the RMW cycle of a byte store must not write memory.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h55;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_dm_we", 32'(bus.dm_we), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_dm_addr", 32'(bus.dm_addr), 32'd0);
    check("abort_dm_din", bus.dm_din, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_hold_dm_we", 32'(bus.dm_we), 32'd0);
    end
    check("abort_mem_word4", mem[4], ref_mem[4]);
    rst_n = 1'b1;

    // Backpressure: response held 5 cycles while the next request waits.
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, m_rd, m_er, m_lat, m_wes);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.resp_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 32'h11;
    n = 0;
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_resp_rdata", bus.resp_rdata, m_rd);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_after_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("bp_after_hs_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_next_accepted", 32'(bus.req_ready), 32'd0);
    model(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, m_rd, m_er, m_lat, m_wes);
    n = 0;
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_rdata", bus.resp_rdata, m_rd);
    bus.resp_ready = 1'b1;
    @(posedge clk);

    // Random traffic against the reference model.
    for (int t = 0; t < 300; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      n     = $urandom_range(0, 7);
      size  = (n < 7) ? 2'(n % 3) : 2'd3;
      addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      wdata = $urandom;
      stall = $urandom_range(0, 3);
      xact(we, size, uns, addr, wdata, stall, rd_first, rd, er, lat, wes);
      model(we, size, uns, addr, wdata, m_rd, m_er, m_lat, m_wes);
      check("rand_rdata_first", rd_first, m_rd);
      check("rand_rdata", rd, m_rd);
      check("rand_err", 32'(er), 32'(m_er));
      check("rand_latency", 32'(lat), 32'(m_lat));
      check("rand_we_pulses", 32'(wes), 32'(m_wes));
      check("rand_mem_word", mem[addr[11:2]], ref_mem[addr[11:2]]);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
